pc_unit: RTL and testbench

Parametrised program-counter sequencer for the next-generation CPU core.
- Replaces the inline PC register and branch mux currently inside the CPU top.
- Adds BGE/BGT conditions, a hardware return-address stack (RAS) and sticky stack-error flags.
- Sits between the control FSM (drives pc_load/cmd) and memory addressing (consumes pc); the datapath supplies flags and the register-sourced target.

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/ras_stack.sv | 55 +++++
 rtl/pc_unit.sv | 124 ++++++++++++
 tb/tb_pc_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the CPU core: PC sequencer command and branch-condition codes,
// default widths, and the branch-condition evaluator.
package cpu_pkg;

  localparam int PC_ADDR_W    = 9;
  localparam int PC_IMM_W     = 8;
  localparam int PC_RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    CMD_INC      = 3'b000,
    CMD_COND     = 3'b001,
    CMD_CALL_REL = 3'b010,
    CMD_CALL_ABS = 3'b011,
    CMD_JUMP_ABS = 3'b100,
    CMD_RET      = 3'b101,
    CMD_HOLD     = 3'b110,
    CMD_RESTART  = 3'b111
  } pc_cmd_t;

  typedef enum logic [2:0] {
    COND_B     = 3'b000,
    COND_BEQ   = 3'b001,
    COND_BNE   = 3'b010,
    COND_BLT   = 3'b011,
    COND_BLE   = 3'b100,
    COND_BGE   = 3'b101,
    COND_BGT   = 3'b110,
    COND_NEVER = 3'b111
  } cond_t;

  // Signed comparisons come from N^V; Z refines them into the "or equal" forms.
  function automatic logic cond_true(input cond_t c, input logic n, input logic v,
                                     input logic z);
    logic lt;
    lt = n ^ v;
    case (c)
      COND_B:     return 1'b1;
      COND_BEQ:   return z;
      COND_BNE:   return ~z;
      COND_BLT:   return lt;
      COND_BLE:   return lt | z;
      COND_BGE:   return ~lt;
      COND_BGT:   return ~lt & ~z;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. Pushing when full silently overwrites the
// oldest entry; the caller is told through overflow_evt.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         overflow_evt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [CW-1:0] count;

  assign top          = mem[ptr - PTR_ONE];
  assign empty        = (count == '0);
  assign full         = (count == CNT_MAX);
  assign overflow_evt = push & full;

  // ptr wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (flush) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_ONE;
      if (!full) count <= count + CNT_ONE;
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_ONE;
      count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= din;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter sequencer: next-PC selection, conditional branches, calls and
// returns through a hardware return-address stack with sticky error flags.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = PC_ADDR_W,
  parameter int                IMM_W     = PC_IMM_W,
  parameter int                RAS_DEPTH = PC_RAS_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_load,
  input  pc_cmd_t           cmd,
  input  logic [2:0]        cond,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] target,
  input  logic              N,
  input  logic              V,
  input  logic              Z,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] link,
  output logic              taken,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] ras_top;
  logic              push_req;
  logic              pop_req;
  logic              flush_req;
  logic              underflow_evt;
  logic              overflow_evt;

  generate
    if (IMM_W >= ADDR_W) begin : g_off_trunc
      assign off = imm[ADDR_W-1:0];
    end else begin : g_off_sext
      assign off = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
    end
  endgenerate

  assign link = pc;

  always_comb begin
    pc_next       = pc;
    taken         = 1'b0;
    push_req      = 1'b0;
    pop_req       = 1'b0;
    flush_req     = 1'b0;
    underflow_evt = 1'b0;
    case (cmd)
      CMD_INC:  pc_next = pc + 1'b1;
      CMD_COND: begin
        taken   = cond_true(cond_t'(cond), N, V, Z);
        pc_next = taken ? pc + off : pc;
      end
      CMD_CALL_REL: begin
        taken    = 1'b1;
        pc_next  = pc + off;
        push_req = 1'b1;
      end
      CMD_CALL_ABS: begin
        taken    = 1'b1;
        pc_next  = target;
        push_req = 1'b1;
      end
      CMD_JUMP_ABS: begin
        taken   = 1'b1;
        pc_next = target;
      end
      CMD_RET: begin
        taken = 1'b1;
        if (!ras_empty) begin
          pc_next = ras_top;
          pop_req = 1'b1;
        end else begin
          pc_next       = target;
          underflow_evt = 1'b1;
        end
      end
      CMD_RESTART: begin
        taken     = 1'b1;
        pc_next   = RESET_PC;
        flush_req = 1'b1;
      end
      default: pc_next = pc;
    endcase
  end

  // Stack requests are qualified here so that nothing moves without a commit.
  ras_stack #(
    .DEPTH(RAS_DEPTH),
    .W    (ADDR_W)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .push        (push_req & pc_load),
    .pop         (pop_req & pc_load),
    .flush       (flush_req & pc_load),
    .din         (pc),
    .top         (ras_top),
    .empty       (ras_empty),
    .full        (ras_full),
    .overflow_evt(overflow_evt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc            <= RESET_PC;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (pc_load) begin
      pc <= pc_next;
      if (overflow_evt)  ras_overflow  <= 1'b1;
      if (underflow_evt) ras_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed and random checks of pc_unit against a queue-based model of the
// program counter and return-address stack.
module tb_pc_unit;
  import cpu_pkg::*;

  localparam int AW    = 9;
  localparam int IW    = 8;
  localparam int DEPTH = 4;
  localparam int MASK  = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          pc_load;
  pc_cmd_t       cmd;
  logic [2:0]    cond;
  logic [IW-1:0] imm;
  logic [AW-1:0] target;
  logic          N, V, Z;
  logic [AW-1:0] pc, pc_next, link;
  logic          taken, ras_empty, ras_full, ras_overflow, ras_underflow;

  pc_unit #(
    .ADDR_W   (AW),
    .IMM_W    (IW),
    .RAS_DEPTH(DEPTH),
    .RESET_PC (9'h000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_load      (pc_load),
    .cmd          (cmd),
    .cond         (cond),
    .imm          (imm),
    .target       (target),
    .N            (N),
    .V            (V),
    .Z            (Z),
    .pc           (pc),
    .pc_next      (pc_next),
    .link         (link),
    .taken        (taken),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int m_pc;
  int ras[$];
  bit m_ovf, m_unf;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_holds(input int c, input bit n, input bit v, input bit z);
    bit less;
    less = (n != v);
    case (c)
      0:       return 1'b1;
      1:       return z;
      2:       return !z;
      3:       return less;
      4:       return less || z;
      5:       return !less;
      6:       return !less && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkState();
    checkOutput("pc", pc, m_pc);
    checkOutput("ras_empty", ras_empty, ras.size() == 0);
    checkOutput("ras_full", ras_full, ras.size() == DEPTH);
    checkOutput("ras_overflow", ras_overflow, m_ovf);
    checkOutput("ras_underflow", ras_underflow, m_unf);
  endtask

  task automatic modelReset();
    m_pc = 0;
    ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input pc_cmd_t c, input int cnd, input int im, input int tgt,
                               input bit n, input bit v, input bit z, input bit load);
    int off, exp_next;
    bit exp_taken;
    cmd = c; cond = 3'(cnd); imm = IW'(im); target = AW'(tgt);
    N = n; V = v; Z = z; pc_load = load;
    off = int'($signed(imm));
    exp_taken = 1'b1;
    case (c)
      CMD_INC:      begin exp_next = m_pc + 1; exp_taken = 1'b0; end
      CMD_COND:     begin
        exp_taken = cond_holds(cnd, n, v, z);
        exp_next  = exp_taken ? m_pc + off : m_pc;
      end
      CMD_CALL_REL: exp_next = m_pc + off;
      CMD_CALL_ABS: exp_next = tgt;
      CMD_JUMP_ABS: exp_next = tgt;
      CMD_RET:      exp_next = (ras.size() > 0) ? ras[$] : tgt;
      CMD_HOLD:     begin exp_next = m_pc; exp_taken = 1'b0; end
      default:      exp_next = 0;
    endcase
    exp_next = exp_next & MASK;
    #1;
    checkOutput("pc_next", pc_next, exp_next);
    checkOutput("taken", taken, exp_taken);
    checkOutput("link", link, m_pc);
    @(posedge clk);
    if (load) begin
      case (c)
        CMD_CALL_REL, CMD_CALL_ABS: begin
          if (ras.size() == DEPTH) begin
            void'(ras.pop_front());
            m_ovf = 1'b1;
          end
          ras.push_back(m_pc);
        end
        CMD_RET: begin
          if (ras.size() > 0) void'(ras.pop_back());
          else m_unf = 1'b1;
        end
        CMD_RESTART: ras.delete();
        default: ;
      endcase
      m_pc = exp_next;
    end
    @(negedge clk);
    checkState();
  endtask

  initial begin
    $display("[TB] pc_unit test starting");
    reset = 1'b0; pc_load = 1'b0; cmd = CMD_INC; cond = '0; imm = '0; target = '0;
    N = 1'b0; V = 1'b0; Z = 1'b0;
    modelReset();
    #1;
    checkState();
    @(negedge clk);
    reset = 1'b1;

    // Conditional BEQ backwards, taken and not taken.
    applyStimulus(CMD_JUMP_ABS, 0, 0, 'h010, 0, 0, 0, 1);
    applyStimulus(CMD_COND, 1, 'hFC, 0, 0, 0, 1, 1);
    applyStimulus(CMD_JUMP_ABS, 0, 0, 'h010, 0, 0, 0, 1);
    applyStimulus(CMD_COND, 1, 'hFC, 0, 0, 0, 0, 1);

    // Relative call and matching return.
    applyStimulus(CMD_JUMP_ABS, 0, 0, 'h003, 0, 0, 0, 1);
    applyStimulus(CMD_CALL_REL, 0, 'h20, 0, 0, 0, 0, 1);
    applyStimulus(CMD_RET, 0, 0, 0, 0, 0, 0, 1);

    // Overfill the stack, drain it, then underflow.
    applyStimulus(CMD_JUMP_ABS, 0, 0, 'h001, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(CMD_CALL_ABS, 0, 0, 'h100 + i, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(CMD_RET, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(CMD_RET, 0, 0, 'h1FF, 0, 0, 0, 1);

    // BGE/BGT with equal and differing N/V, plus wrap-around.
    applyStimulus(CMD_JUMP_ABS, 0, 0, 'h1FE, 0, 0, 0, 1);
    applyStimulus(CMD_COND, 5, 'h05, 0, 1, 1, 0, 1);
    applyStimulus(CMD_COND, 6, 'h05, 0, 1, 1, 0, 1);
    applyStimulus(CMD_COND, 5, 'h05, 0, 1, 0, 0, 1);
    applyStimulus(CMD_COND, 6, 'h05, 0, 1, 0, 0, 1);

    // No commit without pc_load.
    for (int i = 0; i < 3; i++) applyStimulus(CMD_CALL_REL, 0, 'h10, 0, 0, 0, 0, 0);

    applyStimulus(CMD_RESTART, 0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(pc_cmd_t'(3'($urandom_range(0, 7))), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, MASK)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0);
    end

    // Asynchronous reset in the middle of a pending call.
    applyStimulus(CMD_JUMP_ABS, 0, 0, 'h05A, 0, 0, 0, 1);
    applyStimulus(CMD_CALL_ABS, 0, 0, 'h0AA, 0, 0, 0, 1);
    cmd = CMD_CALL_REL; imm = 8'h10; pc_load = 1'b1;
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkState();
    @(posedge clk);
    @(negedge clk);
    checkState();
    reset = 1'b1;
    applyStimulus(CMD_INC, 0, 0, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
